// File: rtl/morse_char_assembler.sv
// morse_char_assembler
//   Assembles dot/dash elements from the Morse decoder into letters and
//   translates each letter to ASCII on a letter/word gap. Characters go into
//   a DEPTH-entry FIFO that a consumer drains with a valid/ready handshake.
//
//   Optional feature: define MORSE_DIGITS_EN to translate five-element codes
//   to the digits '0'-'9'. Without it every five-element code becomes '?'.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   dot, dash    element strobes (a rising edge is one event)
//   lg, wg       letter gap / word gap strobes
//   char_data    ASCII character at the FIFO head
//   char_valid   FIFO head valid
//   char_ready   consumer takes char_data this cycle
//   overflow     sticky, a character was dropped because the FIFO was full
//   elem_count   elements held for the current letter (0-6)
//
// state       | meaning
// ------------+-------------------------------------------------
// IDLE        | letter buffer empty, nothing pending
// COLLECT     | gathering elements of a letter
// EMIT        | pushing the translated letter into the FIFO
// EMIT_SPACE  | pushing the space that closes a word

module morse_char_assembler #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dot,
    input  logic       dash,
    input  logic       lg,
    input  logic       wg,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       overflow,
    output logic [2:0] elem_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT, S_EMIT_SPACE} state_t;

    state_t      state;
    logic [3:0]  strb_q, strb_qq;   // {wg, lg, dash, dot}
    logic [3:0]  ev;
    logic        dot_ev, dash_ev, lg_ev, wg_ev, elem_ev, gap_ev;
    logic [4:0]  code, code_n;
    logic [2:0]  len, len_n;
    logic        bad, bad_n;
    logic [7:0]  char_pend;
    logic        wg_pend;
    logic        last_space;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_ap;
    logic [AW:0] count, count_ap;
    logic        full, pop, push_en, push_ok;
    logic [7:0]  push_data;

    function automatic logic [7:0] xlate(input logic [2:0] n, input logic [4:0] c,
                                         input logic b);
        logic [7:0] r;
        r = 8'h3F;
        if (!b) begin
            case (n)
                3'd1: r = c[0] ? 8'h54 : 8'h45;
                3'd2: case (c[1:0])
                        2'd0: r = 8'h49;  2'd1: r = 8'h41;
                        2'd2: r = 8'h4E;  2'd3: r = 8'h4D;
                        default: r = 8'h3F;
                      endcase
                3'd3: case (c[2:0])
                        3'd0: r = 8'h53;  3'd1: r = 8'h55;
                        3'd2: r = 8'h52;  3'd3: r = 8'h57;
                        3'd4: r = 8'h44;  3'd5: r = 8'h4B;
                        3'd6: r = 8'h47;  3'd7: r = 8'h4F;
                        default: r = 8'h3F;
                      endcase
                3'd4: case (c[3:0])
                        4'd0:  r = 8'h48;  4'd1:  r = 8'h56;
                        4'd2:  r = 8'h46;  4'd4:  r = 8'h4C;
                        4'd6:  r = 8'h50;  4'd7:  r = 8'h4A;
                        4'd8:  r = 8'h42;  4'd9:  r = 8'h58;
                        4'd10: r = 8'h43;  4'd11: r = 8'h59;
                        4'd12: r = 8'h5A;  4'd13: r = 8'h51;
                        default: r = 8'h3F;
                      endcase
`ifdef MORSE_DIGITS_EN
                3'd5: case (c)
                        5'b11111: r = 8'h30;  5'b01111: r = 8'h31;
                        5'b00111: r = 8'h32;  5'b00011: r = 8'h33;
                        5'b00001: r = 8'h34;  5'b00000: r = 8'h35;
                        5'b10000: r = 8'h36;  5'b11000: r = 8'h37;
                        5'b11100: r = 8'h38;  5'b11110: r = 8'h39;
                        default:  r = 8'h3F;
                      endcase
`endif
                default: r = 8'h3F;
            endcase
        end
        return r;
    endfunction

    assign ev      = strb_q & ~strb_qq;
    assign dot_ev  = ev[0];
    assign dash_ev = ev[1];
    assign lg_ev   = ev[2];
    assign wg_ev   = ev[3];
    assign elem_ev = dot_ev | dash_ev;
    assign gap_ev  = lg_ev | wg_ev;

    // Buffer after this cycle's element; a gap in the same cycle sees this.
    always_comb begin
        code_n = code;
        len_n  = len;
        bad_n  = bad;
        if (dot_ev && dash_ev) begin
            bad_n = 1'b1;
            if (len != 3'd6) len_n = len + 3'd1;
        end else if (elem_ev) begin
            if (len >= 3'd5) begin
                len_n = 3'd6;
                bad_n = 1'b1;
            end else begin
                code_n = {code[3:0], dash_ev};
                len_n  = len + 3'd1;
            end
        end
    end

    assign push_en   = (state == S_EMIT) || (state == S_EMIT_SPACE);
    assign push_data = (state == S_EMIT) ? char_pend : 8'h20;
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = char_valid && char_ready;
    assign push_ok   = push_en && (!full || pop);
    assign count_ap  = count - (AW+1)'(pop);
    assign rd_ptr_ap = rd_ptr + AW'(pop);
    assign elem_count = len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strb_q    <= '0;
            strb_qq   <= '0;
            state     <= S_IDLE;
            code      <= '0;
            len       <= '0;
            bad       <= 1'b0;
            char_pend <= '0;
            wg_pend   <= 1'b0;
        end else begin
            strb_q  <= {wg, lg, dash, dot};
            strb_qq <= strb_q;
            if (gap_ev && len_n != 3'd0) begin
                char_pend <= xlate(len_n, code_n, bad_n);
                wg_pend   <= wg_ev;
                code      <= '0;
                len       <= '0;
                bad       <= 1'b0;
                state     <= S_EMIT;
            end else begin
                code <= code_n;
                len  <= len_n;
                bad  <= bad_n;
                if (wg_ev && !last_space) begin
                    state <= S_EMIT_SPACE;
                end else begin
                    case (state)
                        S_IDLE:       if (elem_ev) state <= S_COLLECT;
                        S_COLLECT:    state <= S_COLLECT;
                        S_EMIT:       state <= wg_pend ? S_EMIT_SPACE
                                             : (len_n != 3'd0 ? S_COLLECT : S_IDLE);
                        S_EMIT_SPACE: state <= (len_n != 3'd0) ? S_COLLECT : S_IDLE;
                        default:      state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // The head register only loads entries written on earlier edges, which
    // gives the one-cycle no-fall-through delay and keeps char_data stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            char_data  <= '0;
            char_valid <= 1'b0;
            overflow   <= 1'b0;
            last_space <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_ptr_ap;
            count      <= count_ap + (AW+1)'(push_ok);
            char_valid <= (count_ap != '0);
            if (count_ap != '0) char_data <= mem[rd_ptr_ap];
            if (push_en && !push_ok) overflow <= 1'b1;
            if (push_en) last_space <= (state == S_EMIT_SPACE);
        end
    end

endmodule

// File: tb/tb_morse_char_assembler.sv
module tb_morse_char_assembler;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dot = 1'b0, dash = 1'b0, lg = 1'b0, wg = 1'b0;
    logic       char_ready = 1'b0;
    logic [7:0] char_data;
    logic       char_valid;
    logic       overflow;
    logic [2:0] elem_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    morse_char_assembler #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dot        (dot),
        .dash       (dash),
        .lg         (lg),
        .wg         (wg),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .overflow   (overflow),
        .elem_count (elem_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // m = {wg, lg, dash, dot}
    task automatic strobe(input logic [3:0] m);
        {wg, lg, dash, dot} = m;
        tick(2);
        {wg, lg, dash, dot} = 4'b0000;
        tick(3);
    endtask

    task automatic letter(input string s, input bit is_wg);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            strobe((c == 8'h2D) ? 4'b0010 : 4'b0001);
        end
        strobe(is_wg ? 4'b1000 : 4'b0100);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        tick(4);
    endtask

    // Scoreboard: every handshake must match the oldest expected character.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset_n && char_valid && char_ready) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h100;
            chk("char_data", {24'h0, char_data}, e);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        string tbl_s[3];
        logic [7:0] tbl_c[3];
        tbl_s[0] = "-.-."; tbl_c[0] = 8'h43;
        tbl_s[1] = "--.."; tbl_c[1] = 8'h5A;
        tbl_s[2] = ".---"; tbl_c[2] = 8'h4A;

        tick(3);
        chk("rst_valid", char_valid, 0);
        chk("rst_data", char_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_elem", elem_count, 0);
        reset_n = 1'b1;
        tick(2);
        char_ready = 1'b1;

        // ".-" -> A with element count progression
        strobe(4'b0001);
        chk("elem_1", elem_count, 1);
        strobe(4'b0010);
        chk("elem_2", elem_count, 2);
        exp_q.push_back(8'h41);
        strobe(4'b0100);
        chk("elem_0", elem_count, 0);
        drain(20);

        // S O S and word gap
        exp_q.push_back(8'h53); exp_q.push_back(8'h4F);
        exp_q.push_back(8'h53); exp_q.push_back(8'h20);
        letter("...", 1'b0);
        letter("---", 1'b0);
        letter("...", 1'b1);
        drain(30);
        chk("sos_ovf", overflow, 0);

        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({24'h0, tbl_c[i]});
            letter(tbl_s[i], 1'b0);
        end
        drain(30);

        // six elements -> '?', then repeated word gaps give one space
        for (int i = 0; i < 6; i++) strobe(4'b0001);
        chk("elem_sat", elem_count, 6);
        exp_q.push_back(8'h3F);
        strobe(4'b0100);
        exp_q.push_back(8'h20);
        strobe(4'b1000);
        strobe(4'b1000);
        drain(30);

`ifdef MORSE_DIGITS_EN
        exp_q.push_back(8'h35);
        letter(".....", 1'b0);
        exp_q.push_back(8'h30);
        letter("-----", 1'b0);
`else
        exp_q.push_back(8'h3F);
        letter(".....", 1'b0);
        exp_q.push_back(8'h3F);
        letter("-----", 1'b0);
`endif
        drain(30);

        // dot and dash together
        strobe(4'b0011);
        chk("elem_both", elem_count, 1);
        exp_q.push_back(8'h3F);
        strobe(4'b0100);
        drain(30);

        // fill the FIFO, then one more
        char_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) exp_q.push_back(8'h45);
            letter(".", 1'b0);
            if (i == DEPTH - 1) chk("ovf_at_full", overflow, 0);
        end
        chk("ovf_set", overflow, 1);
        chk("hold_valid", char_valid, 1);
        chk("hold_data", char_data, 8'h45);
        tick(3);
        chk("hold_data2", char_data, 8'h45);
        char_ready = 1'b1;
        drain(40);
        chk("ovf_sticky", overflow, 1);

        // reset mid-letter with characters queued
        char_ready = 1'b0;
        letter(".", 1'b0);
        letter("-", 1'b0);
        for (int i = 0; i < 3; i++) strobe(4'b0001);
        chk("pre_rst_elem", elem_count, 3);
        chk("pre_rst_valid", char_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", char_valid, 0);
        chk("mid_rst_data", char_data, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_elem", elem_count, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        char_ready = 1'b1;
        exp_q.push_back(8'h41);
        letter(".-", 1'b0);
        drain(30);
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_char_assembler.md
# morse_char_assembler

Downstream stage of the Morse decoder. Consumes its `dot`, `dash`, `lg` (letter gap) and `wg` (word gap) strobes and assembles the elements of each letter. On each gap it translates the letter into an 8-bit ASCII code and pushes it into a small output FIFO. A terminal or display consumer drains the FIFO through a valid/ready handshake.

## Interface

Parameters:
- `DEPTH`, 8: output FIFO entries; power of two, 2 to 64.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `dot` input 1: dot element strobe from the decoder.
- `dash` input 1: dash element strobe from the decoder.
- `lg` input 1: letter gap strobe.
- `wg` input 1: word gap strobe.
- `char_data` output 8: ASCII character at the FIFO head.
- `char_valid` output 1: FIFO non-empty.
- `char_ready` input 1: consumer accepts `char_data` this cycle.
- `overflow` output 1: sticky flag, set when a character is dropped because the FIFO is full.
- `elem_count` output 3: number of elements held for the current letter (0–6).

## Operation

**Input conditioning**
- All four strobes are registered once.
- A rising edge of the registered value is one event. A level held for several cycles counts once.

**Letter buffer**
- `code[4:0]` and `len[2:0]`.
- Dot shifts in 0 and dash shifts in 1: `code <= {code[3:0], bit}`, `len <= len+1`.
- The LSB holds the last element.
- A 6th element sets an internal `bad` flag. `len` saturates at 6 and `code` is frozen.
- Dot and dash events in the same cycle: no shift; `bad` is set.

**Gap handling**
- An element event and a gap event in the same cycle: the element is added first, then the gap is processed with the updated buffer.
- `lg` with `len`=0: no action.
- `lg` with `len`>0: push one character, then clear `code`, `len` and `bad`.
- `wg` with `len`>0: push the letter, then push a space (0x20) on the next cycle.
- `wg` with `len`=0: push a space only if the last pushed character was not a space. This suppresses repeated spaces.
- `lg` and `wg` in the same cycle: treated as `wg`.

**FSM states**
- IDLE → COLLECT: on the first element.
- COLLECT → EMIT: on a gap.
- EMIT → EMIT_SPACE: if the gap was `wg`.
- EMIT → IDLE: if the gap was `lg`.
- EMIT_SPACE → IDLE.
- Element events during EMIT or EMIT_SPACE go into the already-cleared buffer and start the next letter. FSM returns to COLLECT.

**Translation** (International Morse)
- Letters A–Z map to 0x41–0x5A, e.g. len=2 code=01 → 'A'; len=4 code=0000 → 'H'.
- Any unmapped (len, code) pair maps to '?' (0x3F).
- A letter with `bad` set also maps to '?'.

**FIFO**
- Push occurs when not full. A push while full is dropped and sets `overflow`.
- Pop occurs when `char_valid && char_ready`.
- Push and pop in the same cycle while full: both succeed.
- No fall-through: a push into an empty FIFO makes `char_valid` high on the following cycle.
- `char_data` stays stable while `char_valid && !char_ready`.
- Pointers wrap modulo `DEPTH`. The count has log2(DEPTH)+1 bits.

**Reset values**
- `char_data`=0, `char_valid`=0, `overflow`=0, `elem_count`=0.
- FSM in IDLE, FIFO empty, last-pushed-space flag cleared.
- Reset mid-letter discards the partial letter and all FIFO contents.

## Timing

- Strobe first sampled high at edge T: event detected in the cycle after T; buffer updated at edge T+1.
- Gap sampled at edge T: letter written to the FIFO at edge T+2. `char_valid` is high after edge T+3 if the FIFO was empty.
- Space (for `wg`) is written one cycle after the letter.
- Pop latency: the next entry is presented on the cycle after a handshake.
- Throughput: 1 character per cycle.
- Decoder strobes are ≥1 unit (millions of cycles) apart, so EMIT/EMIT_SPACE never collide with the next gap. The behaviour above still holds if they do.

## Configuration

- `MORSE_DIGITS_EN` defined:
  - Five-element digit codes translate to '0'–'9' (0x30–0x39), e.g. len=5 code=00000 → '5', code=11111 → '0'.
  - A 6th element still yields '?'.
- `MORSE_DIGITS_EN` undefined:
  - All len=5 codes translate to '?'.
  - Digit ROM logic is absent.

## Test plan

- `dot`,`dash`,`lg` with `char_ready`=1 → one transfer `char_data`=0x41; `elem_count` sequence 1,2,0.
- "..." lg, "---" lg, "..." wg → transfers 0x53,0x4F,0x53,0x20 in order; `overflow`=0.
- `char_ready`=0, push DEPTH+1 letters "." lg (8 default) → `overflow`=1 after the 9th; then drain → exactly 8×0x45; `overflow` stays 1.
- 6 dots then lg → 0x3F; then `wg`,`wg` with empty buffer → exactly one 0x20.
- "....." lg → 0x35 with `MORSE_DIGITS_EN`, 0x3F without; `dot` and `dash` in the same cycle then lg → 0x3F.
- Assert `reset_n`=0 after 3 elements with 2 characters queued → all outputs 0 immediately; after release, ".-" lg → single 0x41.
